// File: rtl/soc_bus_pkg.sv
// Shared SoC bus constants, requester map and lock FSM states
// for the RAM port arbiter.
package soc_bus_pkg;

  localparam int AW_SOC = 19;
  localparam int DW_SOC = 19;

  localparam int REQ_CPU    = 0;
  localparam int REQ_FFT    = 1;
  localparam int REQ_CRYPTO = 2;

  typedef enum logic {
    IDLE,
    LOCKED
  } lock_state_e;

endpackage

// File: rtl/ram_port_arbiter_rr_pick2.sv
// Two-way round-robin pick between the FFT and CRYPTO masters.
// i_rr_ptr holds the requester index (1 or 2) that is looked at first.
module rr_pick2
  import soc_bus_pkg::*;
(
  input  logic [1:0] i_rr_ptr,
  input  logic [1:0] i_acc_valid,
  output logic [1:0] o_pick
);

  logic w_start_crypto;

  assign w_start_crypto = (i_rr_ptr == 2'(REQ_CRYPTO));

  always_comb begin
    o_pick = '0;
    if (w_start_crypto) begin
      if (i_acc_valid[1])      o_pick = 2'b10;
      else if (i_acc_valid[0]) o_pick = 2'b01;
    end else begin
      if (i_acc_valid[0])      o_pick = 2'b01;
      else if (i_acc_valid[1]) o_pick = 2'b10;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Single RAM port shared by CPU, FFT and CRYPTO masters: CPU priority
// with a starvation bound, accelerator round-robin and burst locking.
module ram_port_arbiter
  import soc_bus_pkg::*;
#(
  parameter int AW             = AW_SOC,
  parameter int DW             = DW_SOC,
  parameter int N_REQ          = 3,
  parameter int CPU_STREAK_MAX = 4,
  parameter int LOCK_MAX       = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ-1:0]    req_write,
  input  logic [N_REQ-1:0]    req_lock,
  input  logic [N_REQ*AW-1:0] req_addr,
  input  logic [N_REQ*DW-1:0] req_wdata,
  output logic [N_REQ-1:0]    req_ready,
  output logic [N_REQ-1:0]    rsp_valid,
  output logic [DW-1:0]       rsp_rdata,
  output logic                ram_en,
  output logic                ram_we,
  output logic [AW-1:0]       ram_addr,
  output logic [DW-1:0]       ram_wdata,
  input  logic [DW-1:0]       ram_rdata,
  output logic [1:0]          gnt_id,
  output logic                lock_timeout
);

  localparam int SW = $clog2(CPU_STREAK_MAX + 1);
  localparam int CW = $clog2(LOCK_MAX + 1);

  lock_state_e      r_state;
  lock_state_e      w_state_nxt;
  logic [1:0]       r_owner;
  logic [1:0]       w_owner_nxt;
  logic [CW-1:0]    r_lock_cnt;
  logic [CW-1:0]    w_lock_cnt_nxt;
  logic             r_ban_vld;
  logic             w_ban_vld_nxt;
  logic [1:0]       r_ban_id;
  logic [1:0]       w_ban_id_nxt;
  logic             r_timeout;
  logic             w_timeout_nxt;
  logic [1:0]       r_rr_ptr;
  logic [SW-1:0]    r_streak;
  logic [N_REQ-1:0] r_rsp_vld;

  logic             w_acc_any;
  logic             w_lock_hold;
  logic             w_cpu_ok;
  logic [1:0]       w_acc_pick;
  logic [N_REQ-1:0] w_gnt;
  logic             w_gnt_any;
  logic             w_gnt_acc;
  logic [1:0]       w_gid;
  logic             w_we;
  logic             w_lock_bit;
  logic             w_banned;

  assign w_acc_any = req_valid[REQ_FFT] | req_valid[REQ_CRYPTO];

  // An owner that drops valid loses the lock and normal arbitration runs
  assign w_lock_hold = (r_state == LOCKED) && req_valid[r_owner];

  assign w_cpu_ok = req_valid[REQ_CPU] &&
                    ((r_streak < SW'(CPU_STREAK_MAX)) || !w_acc_any);

  rr_pick2 u_pick (
    .i_rr_ptr    (r_rr_ptr),
    .i_acc_valid (req_valid[REQ_CRYPTO:REQ_FFT]),
    .o_pick      (w_acc_pick)
  );

  always_comb begin
    w_gnt = '0;
    if (!rst) begin
      priority case (1'b1)
        w_lock_hold:   w_gnt = N_REQ'(1) << r_owner;
        w_cpu_ok:      w_gnt[REQ_CPU] = 1'b1;
        |w_acc_pick:   w_gnt = {w_acc_pick, 1'b0};
        default:       w_gnt = '0;
      endcase
    end
  end

  always_comb begin
    w_gid = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_gnt[i]) w_gid = 2'(i);
    end
  end

  assign w_gnt_any  = |w_gnt;
  assign w_gnt_acc  = w_gnt[REQ_FFT] | w_gnt[REQ_CRYPTO];
  assign w_we       = w_gnt_any & req_write[w_gid];
  assign w_lock_bit = w_gnt_any & req_lock[w_gid];
  assign w_banned   = r_ban_vld && (r_ban_id == w_gid);

  assign req_ready = w_gnt;
  assign gnt_id    = w_gid;
  assign ram_en    = w_gnt_any;
  assign ram_we    = w_we;
  assign ram_addr  = w_gnt_any ? req_addr[w_gid*AW +: AW] : '0;
  assign ram_wdata = w_gnt_any ? req_wdata[w_gid*DW +: DW] : '0;

  always_comb begin
    w_state_nxt    = r_state;
    w_owner_nxt    = r_owner;
    w_lock_cnt_nxt = r_lock_cnt;
    w_ban_vld_nxt  = r_ban_vld;
    w_ban_id_nxt   = r_ban_id;
    w_timeout_nxt  = 1'b0;
    if (w_lock_hold) begin
      if (!w_lock_bit) begin
        w_state_nxt    = IDLE;
        w_lock_cnt_nxt = '0;
      end else if (r_lock_cnt == CW'(LOCK_MAX - 1)) begin
        w_state_nxt    = IDLE;
        w_lock_cnt_nxt = '0;
        w_timeout_nxt  = 1'b1;
        w_ban_vld_nxt  = 1'b1;
        w_ban_id_nxt   = r_owner;
      end else begin
        w_lock_cnt_nxt = r_lock_cnt + 1'b1;
      end
    end else begin
      w_state_nxt    = IDLE;
      w_lock_cnt_nxt = '0;
      if (w_gnt_any) begin
        w_ban_vld_nxt = 1'b0;
        if (w_lock_bit && !w_banned) begin
          w_state_nxt    = LOCKED;
          w_owner_nxt    = w_gid;
          w_lock_cnt_nxt = CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_owner    <= '0;
      r_lock_cnt <= '0;
      r_ban_vld  <= 1'b0;
      r_ban_id   <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_owner    <= w_owner_nxt;
      r_lock_cnt <= w_lock_cnt_nxt;
      r_ban_vld  <= w_ban_vld_nxt;
      r_ban_id   <= w_ban_id_nxt;
      r_timeout  <= w_timeout_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= 2'(REQ_FFT);
    end else if (w_gnt_acc) begin
      r_rr_ptr <= w_gnt[REQ_CRYPTO] ? 2'(REQ_FFT) : 2'(REQ_CRYPTO);
    end
  end

  // Streak is frozen while a lock is held
  always_ff @(posedge clk) begin
    if (rst) begin
      r_streak <= '0;
    end else if (r_state == IDLE) begin
      if (!w_acc_any) begin
        r_streak <= '0;
      end else if (w_gnt[REQ_CPU]) begin
        if (r_streak < SW'(CPU_STREAK_MAX)) r_streak <= r_streak + 1'b1;
      end else if (w_gnt_acc) begin
        r_streak <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_vld <= '0;
    end else begin
      r_rsp_vld <= w_we ? '0 : w_gnt;
    end
  end

  assign rsp_valid    = rst ? '0 : r_rsp_vld;
  assign rsp_rdata    = (|rsp_valid) ? ram_rdata : '0;
  assign lock_timeout = r_timeout & ~rst;

endmodule
